// File: rtl/dlx_alu_issue_if.sv
// -----------------------------------------------------------------------------
// dlx_alu_issue_if
//   Bundles every non-clock/reset signal of the DLX ALU issue/writeback block.
//   slave  : the issue controller (dlx_alu_issue)
//   master : the surrounding environment (fetch stage, ALU, loader, debugger)
//
//   instr_valid/instr_ready/instr : R-type instruction handshake
//   alu_a/alu_b/alu_func          : registered operands and func to the ALU
//   alu_result                    : combinational ALU output
//   done/illegal                  : one-cycle completion / rejection pulses
//   wb_rd/wb_data                 : current or last writeback
//   ld_en/ld_addr/ld_data         : boot/test register load port
//   dbg_addr/dbg_data             : asynchronous debug read of the register file
// -----------------------------------------------------------------------------
interface dlx_alu_issue_if #(
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [5:0]        alu_func;
    logic [DATA_W-1:0] alu_result;
    logic              done;
    logic              illegal;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              ld_en;
    logic [4:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [4:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  instr_valid,
        output instr_ready,
        input  instr,
        output alu_a,
        output alu_b,
        output alu_func,
        input  alu_result,
        output done,
        output illegal,
        output wb_rd,
        output wb_data,
        input  ld_en,
        input  ld_addr,
        input  ld_data,
        input  dbg_addr,
        output dbg_data
    );

    modport master (
        output instr_valid,
        input  instr_ready,
        output instr,
        input  alu_a,
        input  alu_b,
        input  alu_func,
        output alu_result,
        input  done,
        input  illegal,
        input  wb_rd,
        input  wb_data,
        output ld_en,
        output ld_addr,
        output ld_data,
        output dbg_addr,
        input  dbg_data
    );
endinterface

// File: rtl/dlx_alu_issue.sv
// -----------------------------------------------------------------------------
// dlx_alu_issue
//   Serial issue/writeback controller for the combinational 32-bit DLX ALU.
//   Accepts one R-type instruction at a time, reads rs1/rs2 from an internal
//   32x32 register file, presents them to the ALU, samples the result and
//   writes it back to rd. One instruction per four cycles.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset (FSM, register file, outputs)
//     bus  : dlx_alu_issue_if.slave, see the interface for signal meanings
//
//   Timeline for an accept in cycle T
//     T+1 READ : operands and func registered towards the ALU
//     T+2 EXEC : ALU inputs stable, result captured into wb_data at the edge
//     T+3 WB   : done pulse, register file written (unless rd == 0)
//     T+4 IDLE : ready again
//   An illegal instruction goes to ERR at T+1 (illegal pulse), IDLE at T+2.
// -----------------------------------------------------------------------------
module dlx_alu_issue #(
    parameter int DATA_W    = 32,
    parameter bit CHECK_OPC = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    dlx_alu_issue_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    // Legal DLX R-type func codes handled by the ALU.
    function automatic logic func_is_legal(input logic [5:0] f);
        case (f)
            6'h04, 6'h06, 6'h07,
            6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
            6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D: func_is_legal = 1'b1;
            default:                                  func_is_legal = 1'b0;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t            state_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [4:0]        rd_q;
    logic [5:0]        func_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [5:0]        alu_func_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [4:0]        wb_rd_q;
    logic              done_q;
    logic              illegal_q;

    // Register file. Entry 0 is never written so it always reads as zero.
    logic [DATA_W-1:0] rf_q [32];

    // -------------------------------------------------------------------------
    // Instruction decode at accept time
    // -------------------------------------------------------------------------
    logic       ready;
    logic       accept;
    logic [5:0] instr_opc;
    logic [5:0] instr_func;
    logic       instr_legal;

    assign ready       = (state_q == S_IDLE);
    assign accept      = bus.instr_valid && ready;
    assign instr_opc   = bus.instr[31:26];
    assign instr_func  = bus.instr[5:0];
    assign instr_legal = func_is_legal(instr_func) &&
                         (!CHECK_OPC || (instr_opc == 6'd0));

    // -------------------------------------------------------------------------
    // Register file write port
    //   Writeback owns the port in WB. A load is taken only in IDLE and only
    //   when no instruction is accepted in the same cycle (the accept wins).
    // -------------------------------------------------------------------------
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state_q == S_WB) begin
            rf_we    = (rd_q != 5'd0);
            rf_waddr = rd_q;
            rf_wdata = wb_data_q;
        end else if (ready && bus.ld_en && !accept) begin
            rf_we    = (bus.ld_addr != 5'd0);
            rf_waddr = bus.ld_addr;
            rf_wdata = bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Register file read with R0 forced to zero regardless of storage content.
    function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] a);
        rf_read = (a == 5'd0) ? '0 : rf_q[a];
    endfunction

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            func_q     <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_func_q <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            // Pulses default low; the transitions below raise them for one cycle.
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rs1_q  <= bus.instr[25:21];
                        rs2_q  <= bus.instr[20:16];
                        rd_q   <= bus.instr[15:11];
                        func_q <= instr_func;
                        if (instr_legal) begin
                            state_q <= S_READ;
                        end else begin
                            state_q   <= S_ERR;
                            illegal_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    // Any writeback from the previous instruction landed in its
                    // WB cycle, so a plain read here is always up to date.
                    alu_a_q    <= rf_read(rs1_q);
                    alu_b_q    <= rf_read(rs2_q);
                    alu_func_q <= func_q;
                    state_q    <= S_EXEC;
                end
                S_EXEC: begin
                    wb_data_q <= bus.alu_result;
                    wb_rd_q   <= rd_q;
                    done_q    <= 1'b1;
                    state_q   <= S_WB;
                end
                S_WB: begin
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output assignments
    // -------------------------------------------------------------------------
    assign bus.instr_ready = ready;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_func    = alu_func_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.dbg_data    = rf_read(bus.dbg_addr);

endmodule

// File: tb/tb_dlx_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_dlx_alu_issue
//   Self-checking bench for dlx_alu_issue: a directed vector table, hand-written
//   corner sequences (held valid, load collisions, reset mid-instruction) and a
//   randomized phase checked against an architectural register-file model.
//   The bench also plays the role of the combinational DLX ALU.
// -----------------------------------------------------------------------------
module tb_dlx_alu_issue;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dlx_alu_issue_if #(.DATA_W(32)) bus ();

    dlx_alu_issue #(
        .DATA_W   (32),
        .CHECK_OPC(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- reference ALU and architectural model -----------------
    function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (f)
            6'h04:   alu_ref = a << b[4:0];
            6'h06:   alu_ref = a >> b[4:0];
            6'h07:   alu_ref = sa >>> b[4:0];
            6'h20:   alu_ref = a + b;
            6'h22:   alu_ref = a - b;
            6'h24:   alu_ref = a & b;
            6'h25:   alu_ref = a | b;
            6'h26:   alu_ref = a ^ b;
            6'h28:   alu_ref = (a == b)  ? 32'd1 : 32'd0;
            6'h29:   alu_ref = (a != b)  ? 32'd1 : 32'd0;
            6'h2A:   alu_ref = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B:   alu_ref = (sa > sb) ? 32'd1 : 32'd0;
            6'h2C:   alu_ref = (sa <= sb) ? 32'd1 : 32'd0;
            6'h2D:   alu_ref = (sa >= sb) ? 32'd1 : 32'd0;
            default: alu_ref = 32'd0;
        endcase
    endfunction

    logic [5:0] legal_funcs [14] = '{6'h04, 6'h06, 6'h07, 6'h20, 6'h22, 6'h24, 6'h25,
                                     6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D};

    function automatic logic is_legal(input logic [5:0] f);
        is_legal = 1'b0;
        foreach (legal_funcs[i]) if (legal_funcs[i] == f) is_legal = 1'b1;
    endfunction

    // The environment's combinational ALU.
    always_comb bus.alu_result = alu_ref(bus.alu_func, bus.alu_a, bus.alu_b);

    logic [31:0] mregs [32];
    logic [31:0] last_a, last_b, last_wb;
    logic [5:0]  last_f;
    logic [4:0]  last_rd;

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = 32'd0;
        last_a = 0; last_b = 0; last_wb = 0; last_f = 0; last_rd = 0;
    endtask

    // ---------------- checking ----------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Caller must be in a cycle where nothing changes the register file.
    task automatic dbg_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.dbg_addr = a;
        #1;
        chk(name, bus.dbg_data, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (bus.instr_ready !== 1'b1) chk("ready_timeout", {31'd0, bus.instr_ready}, 32'd1);
    endtask

    // side: 0 none, 1 load in the accept cycle, 2 load during READ (both dropped)
    task automatic issue(input logic [5:0] opc, input logic [5:0] func,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic ill, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ewb, input int side);
        wait_ready();
        bus.instr       = {opc, rs1, rs2, rd, 5'd0, func};
        bus.instr_valid = 1'b1;
        if (side == 1) begin
            bus.ld_en = 1'b1; bus.ld_addr = 5'd13; bus.ld_data = 32'hDEAD_BEEF;
        end
        step();                                      // T+1
        bus.instr_valid = 1'b0;
        bus.ld_en       = 1'b0;
        chk("ready_low_T1", {31'd0, bus.instr_ready}, 32'd0);
        chk("illegal_T1", {31'd0, bus.illegal}, {31'd0, ill});
        chk("done_T1", {31'd0, bus.done}, 32'd0);
        if (ill) begin
            step();                                  // T+2
            chk("ready_T2_err", {31'd0, bus.instr_ready}, 32'd1);
            chk("illegal_T2", {31'd0, bus.illegal}, 32'd0);
            chk("alu_a_hold", bus.alu_a, last_a);
            chk("alu_func_hold", {26'd0, bus.alu_func}, {26'd0, last_f});
            chk("wb_data_hold", bus.wb_data, last_wb);
            dbg_chk("rd_unchanged", rd, mregs[rd]);
        end else begin
            if (side == 2) begin
                bus.ld_en = 1'b1; bus.ld_addr = 5'd14; bus.ld_data = 32'h1234_5678;
            end
            step();                                  // T+2
            bus.ld_en = 1'b0;
            chk("alu_a", bus.alu_a, ea);
            chk("alu_b", bus.alu_b, eb);
            chk("alu_func", {26'd0, bus.alu_func}, {26'd0, func});
            step();                                  // T+3
            chk("done_T3", {31'd0, bus.done}, 32'd1);
            chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, rd});
            chk("wb_data", bus.wb_data, ewb);
            if (rd != 0) mregs[rd] = ewb;
            last_a = ea; last_b = eb; last_f = func; last_wb = ewb; last_rd = rd;
            step();                                  // T+4
            chk("done_T4", {31'd0, bus.done}, 32'd0);
            chk("ready_T4", {31'd0, bus.instr_ready}, 32'd1);
            dbg_chk("rd_written", rd, mregs[rd]);
        end
        $display("txn opc=%h func=%h rs1=%0d rs2=%0d rd=%0d ill=%0d wb=%h", opc, func, rs1, rs2, rd, ill, ewb);
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        wait_ready();
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        step();
        bus.ld_en = 1'b0;
        if (a != 0) mregs[a] = d;
        dbg_chk("load", a, mregs[a]);
        $display("txn load r%0d=%h", a, d);
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        logic [5:0]  opc;
        logic [5:0]  func;
        logic [4:0]  rs1, rs2, rd;
        logic        ill;
        logic [31:0] ea, eb, ewb;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int done_cnt;
        int guard;

        bus.instr_valid = 0; bus.instr = 0; bus.ld_en = 0;
        bus.ld_addr = 0; bus.ld_data = 0; bus.dbg_addr = 0;
        model_reset();

        // Vectors assume r1=5, r2=3 and run in order (later rows see earlier writes).
        tbl[0] = '{6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0, 32'd5, 32'd3, 32'd8};          // ADD r3
        tbl[1] = '{6'h00, 6'h22, 5'd2, 5'd1, 5'd4, 1'b0, 32'd3, 32'd5, 32'hFFFFFFFE};   // SUB r4
        tbl[2] = '{6'h00, 6'h2A, 5'd1, 5'd2, 5'd5, 1'b0, 32'd5, 32'd3, 32'd0};          // SLT r5
        tbl[3] = '{6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 1'b0, 32'd5, 32'd3, 32'd8};          // ADD r0
        tbl[4] = '{6'h00, 6'h3F, 5'd1, 5'd2, 5'd6, 1'b1, 32'd0, 32'd0, 32'd0};          // bad func
        tbl[5] = '{6'h08, 6'h20, 5'd1, 5'd2, 5'd6, 1'b1, 32'd0, 32'd0, 32'd0};          // bad opcode
        tbl[6] = '{6'h00, 6'h04, 5'd1, 5'd2, 5'd6, 1'b0, 32'd5, 32'd3, 32'd40};         // SLL
        tbl[7] = '{6'h00, 6'h2B, 5'd4, 5'd1, 5'd7, 1'b0, 32'hFFFFFFFE, 32'd5, 32'd0};   // SGT signed
        tbl[8] = '{6'h00, 6'h07, 5'd4, 5'd2, 5'd8, 1'b0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF}; // SRA
        tbl[9] = '{6'h00, 6'h28, 5'd3, 5'd3, 5'd9, 1'b0, 32'd8, 32'd8, 32'd1};          // SEQ

        // Reset for two cycles, then check the reset state.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_alu_func", {26'd0, bus.alu_func}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus.dbg_addr = 5'(i);
            #0;
            chk("rst_reg", bus.dbg_data, 32'd0);
        end
        step();

        load(5'd1, 32'd5);
        load(5'd2, 32'd3);
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].opc, tbl[i].func, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                  tbl[i].ill, tbl[i].ea, tbl[i].eb, tbl[i].ewb, 0);
        end
        load(5'd0, 32'd7);                           // R0 stays zero

        // Load coinciding with accept is dropped; load during READ is ignored.
        issue(6'h00, 6'h25, 5'd1, 5'd2, 5'd12, 1'b0, 32'd5, 32'd3, 32'd7, 1);
        dbg_chk("ld_with_accept_dropped", 5'd13, mregs[13]);
        issue(6'h00, 6'h26, 5'd1, 5'd2, 5'd15, 1'b0, 32'd5, 32'd3, 32'd6, 2);
        dbg_chk("ld_in_read_ignored", 5'd14, mregs[14]);

        // instr_valid held for four cycles yields exactly one instruction.
        wait_ready();
        bus.instr = {6'h00, 5'd1, 5'd2, 5'd10, 5'd0, 6'h20};
        bus.instr_valid = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 3) bus.instr_valid = 1'b0;
            if (bus.done === 1'b1) done_cnt++;
        end
        chk("held_valid_single_done", 32'(done_cnt), 32'd1);
        mregs[10] = 32'd8;
        dbg_chk("held_valid_r10", 5'd10, 32'd8);
        $display("txn held-valid ADD r10 done_count=%0d", done_cnt);

        // Reset asserted while in EXEC discards the instruction.
        wait_ready();
        bus.instr = {6'h00, 5'd1, 5'd2, 5'd11, 5'd0, 6'h20};
        bus.instr_valid = 1'b1;
        step();                                      // T+1 READ
        bus.instr_valid = 1'b0;
        step();                                      // T+2 EXEC
        rst = 1'b1;
        step();                                      // T+3 after reset edge
        rst = 1'b0;
        model_reset();
        chk("rst_exec_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("rst_exec_done", {31'd0, bus.done}, 32'd0);
        chk("rst_exec_alu_a", bus.alu_a, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.done === 1'b1) done_cnt++;
        end
        chk("rst_exec_no_done", 32'(done_cnt), 32'd0);
        for (int i = 1; i < 16; i++) begin
            bus.dbg_addr = 5'(i);
            #0;
            chk("rst_exec_reg", bus.dbg_data, 32'd0);
        end
        $display("txn reset-in-EXEC discarded");

        // Randomized phase against the architectural model.
        for (int i = 1; i < 32; i++) if ($urandom_range(0, 1) == 1) load(5'(i), $urandom);
        guard = 0;
        for (int n = 0; n < 60; n++) begin
            logic [5:0] opc, func;
            logic [4:0] rs1, rs2, rd;
            logic       ill;
            logic [31:0] a, b;
            if ($urandom_range(0, 4) == 0) load(5'($urandom_range(0, 31)), $urandom);
            opc  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            func = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_funcs[$urandom_range(0, 13)];
            rs1  = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            ill  = (opc != 0) || !is_legal(func);
            a    = mregs[rs1];
            b    = mregs[rs2];
            issue(opc, func, rs1, rs2, rd, ill, a, b, alu_ref(func, a, b), 0);
            guard++;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
